// File: rtl/mux_pkg.sv
// ============================================================================
// Module : mux_pkg
// Brief  : Shared helpers for the pipelined N:1 select (range check on select).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mux_pkg;

    // Widths are passed as 32-bit values so any SEL_W zero-extends cleanly.
    function automatic logic sel_in_range(input logic [31:0] sel, input logic [31:0] n);
        return (sel < n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux_n_pipe_skid.sv
// ============================================================================
// Module : skid_buffer
// Brief  : Two-entry (main + skid) valid/ready stage; ready is a pure register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module skid_buffer #(
    parameter int PW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [PW-1:0] i_up_data,
    input  logic          i_up_valid,
    output logic          o_up_ready,
    output logic [PW-1:0] o_dn_data,
    output logic          o_dn_valid,
    input  logic          i_dn_ready
);

    logic [PW-1:0] r_main;
    logic          r_main_valid;
    logic [PW-1:0] r_skid;
    logic          r_skid_valid;
    logic          w_accept;
    logic          w_emit;

    assign w_accept = i_up_valid & ~r_skid_valid;
    assign w_emit   = r_main_valid & i_dn_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main       <= '0;
            r_main_valid <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
        end else if (w_emit) begin
            // A full skid blocks accept, so draining it never collides with new data.
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_main       <= i_up_data;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_main_valid) begin
                r_main       <= i_up_data;
                r_main_valid <= 1'b1;
            end else begin
                r_skid       <= i_up_data;
                r_skid_valid <= 1'b1;
            end
        end
    end

    assign o_up_ready = ~r_skid_valid;
    assign o_dn_data  = r_main;
    assign o_dn_valid = r_main_valid;

endmodule

`default_nettype wire

// File: rtl/mux_n_pipe.sv
// ============================================================================
// Module : mux_n_pipe
// Brief  : Registered N:1 mux with valid/ready, skid buffer and error counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_n_pipe
    import mux_pkg::*;
#(
    parameter  int WIDTH     = 5,
    parameter  int N_INPUTS  = 4,
    parameter  int ERR_CNT_W = 8,
    localparam int SEL_W     = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_INPUTS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_err,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ERR_CNT_W-1:0]      err_count
);

    localparam int ENTRY_W = WIDTH + 1;

    typedef struct packed {
        logic             err;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t                 w_res;
    entry_t                 w_out;
    logic [WIDTH-1:0]       w_sel_data;
    logic                   w_in_range;
    logic                   w_accept;
    logic [ERR_CNT_W-1:0]   r_err_cnt;

    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < N_INPUTS; k++) begin
            if (in_sel == SEL_W'(k)) begin
                w_sel_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_in_range = sel_in_range(32'(in_sel), 32'(N_INPUTS));
    assign w_res.err  = ~w_in_range;
    assign w_res.data = w_in_range ? w_sel_data : '0;
    assign w_accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_accept && w_res.err && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
    end

    skid_buffer #(
        .PW (ENTRY_W)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_up_data  (w_res),
        .i_up_valid (in_valid),
        .o_up_ready (in_ready),
        .o_dn_data  (w_out),
        .o_dn_valid (out_valid),
        .i_dn_ready (out_ready)
    );

    assign out_data  = w_out.data;
    assign out_err   = w_out.err;
    assign err_count = r_err_cnt;

endmodule

`default_nettype wire
